// File: rtl/vpu_ram_pkg.sv
// Shared constants and types for the VPU data-RAM block reader.
package vpu_ram_pkg;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 32;
    localparam int RAM_WORDS = 4096;

    // Reader sequencing: wait for a request, stream the block, pulse completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    // Word counts need one extra bit so a full-RAM block (4096) fits.
    typedef logic [ADDR_W:0] count_t;

endpackage

// File: rtl/vpu_ram_rd_fifo.sv
// Small synchronous FIFO buffering RAM read data ahead of the stream sink.
// Occupancy is kept in a register so the reader's credit logic sees a clean value.
module vpu_ram_rd_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    // Push is dropped when full and pop when empty, so misuse never corrupts state.
    always_comb begin
        do_push  = push && (count_q != FULL_CNT);
        do_pop   = pop && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and occupancy; reset empties the buffer completely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/vpu_ram_block_reader.sv
// Streams a block of words from the VPU data RAM onto a ready/valid source.
// Reads are issued only when the buffer has room for everything in flight,
// so returning RAM data can always be written without a stall path.
//
// Stream handshake: a word transfers on a clock edge where st_valid and
// st_ready are both high; while st_valid is high and st_ready low, st_data,
// st_sop and st_eop hold their values, and st_valid never depends on st_ready.
module vpu_ram_block_reader #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       word_count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     m_address,
    output logic                  m_chipselect,
    output logic                  m_write,
    output logic [3:0]            m_byteenable,
    output logic [DATA_W-1:0]     m_writedata,
    output logic                  m_clken,
    input  logic [DATA_W-1:0]     m_readdata,
    output logic [DATA_W-1:0]     st_data,
    output logic                  st_valid,
    input  logic                  st_ready,
    output logic                  st_sop,
    output logic                  st_eop,
    output vpu_ram_pkg::state_e   dbg_state
);

    import vpu_ram_pkg::*;

    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [ADDR_W:0]         count_q, count_d;
    logic [ADDR_W:0]         issued_q, issued_d;
    logic [ADDR_W:0]         accepted_q, accepted_d;
    logic [READ_LATENCY-1:0] pipe_q, pipe_d;

    logic [ADDR_W:0]         clamped_count;
    logic [FCNT_W-1:0]       fifo_count;
    logic                    fifo_empty;
    logic [DATA_W-1:0]       fifo_head;
    logic                    fifo_push;
    logic                    pop;
    logic                    issue;
    logic                    last_word;
    int                      inflight;
    int                      occupancy;

    // Counts above the RAM size are reduced to one full pass over the RAM.
    always_comb begin
        clamped_count = (word_count > MAX_COUNT) ? MAX_COUNT : word_count;
    end

    // Credit check: reads in flight plus buffered words must leave a free slot.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + int'(pipe_q[i]);
        end
        occupancy = inflight + int'(fifo_count);
        issue     = (state_q == RUN) && (issued_q < count_q) && (occupancy < FIFO_DEPTH);
    end

    // Latency pipe: a bit enters on each issued read and marks its data arrival.
    always_comb begin
        pipe_d[0] = issue;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign fifo_push = pipe_q[READ_LATENCY-1];
    assign pop       = !fifo_empty && st_ready;
    assign last_word = (accepted_q == (count_q - CNT_ONE));

    // Sequencing: latch the request, track issued/accepted words, pulse done.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        issued_d   = issued_q;
        accepted_d = accepted_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d     = base_addr;
                    count_d    = clamped_count;
                    issued_d   = '0;
                    accepted_d = '0;
                    state_d    = (clamped_count == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (issue) begin
                    issued_d = issued_q + CNT_ONE;
                    addr_d   = addr_q + ADDR_W'(1);
                end
                if (pop) begin
                    accepted_d = accepted_q + CNT_ONE;
                    if (last_word) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers; reset abandons any block in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            pipe_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            pipe_q     <= pipe_d;
        end
    end

    vpu_ram_rd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset_n),
        .push      (fifo_push),
        .push_data (m_readdata),
        .pop       (pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign busy         = (state_q == RUN);
    assign done         = (state_q == FIN);
    assign m_address    = addr_q;
    assign m_chipselect = issue;
    assign m_write      = 1'b0;
    assign m_byteenable = 4'hF;
    assign m_writedata  = '0;
    assign m_clken      = 1'b1;
    assign st_valid     = !fifo_empty;
    assign st_data      = fifo_head;
    assign st_sop       = !fifo_empty && (accepted_q == '0);
    assign st_eop       = !fifo_empty && last_word;
    assign dbg_state    = state_q;

endmodule
